// File: rtl/dmem_arbiter_pkg.sv
// Shared types and constants for the data-memory arbiter:
// read-return states, owner encoding and the aging counter width.
package dmem_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_CPU_RD,
    ARB_EXT_RD
  } arb_state_t;

  localparam int unsigned AGE_W = 4;

  localparam logic [1:0] OWN_NONE = 2'd0;
  localparam logic [1:0] OWN_CPU  = 2'd1;
  localparam logic [1:0] OWN_EXT  = 2'd2;

endpackage

// File: rtl/dmem_arbiter_age_counter.sv
// Saturating up-counter with synchronous clear; clear has priority over increment.
// Tracks how many consecutive cycles the external requester has been kept waiting.
module dmem_arbiter_age_counter
  import dmem_arbiter_pkg::*;
(
  input  logic             clk,
  input  logic             arst_n,
  input  logic             i_inc,
  input  logic             i_clr,
  output logic [AGE_W-1:0] o_count
);

  logic [AGE_W-1:0] r_count;
  logic [AGE_W-1:0] w_count_next;

  always_comb begin
    w_count_next = r_count;
    if (i_clr) begin
      w_count_next = '0;
    end else if (i_inc && (r_count != '1)) begin
      w_count_next = r_count + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_count <= '0;
    end else begin
      r_count <= w_count_next;
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the single-port data SRAM between the CPU MEM stage (fixed priority) and the
// external loader/debug port, which wins once it has waited STARVE_LIMIT cycles.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int unsigned DATA_W       = 64,
  parameter int unsigned ADDR_W       = 64,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              arst_n,
  input  logic              enable,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_stall,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              ext_req,
  input  logic              ext_we,
  input  logic [ADDR_W-1:0] ext_addr,
  input  logic [DATA_W-1:0] ext_wdata,
  output logic              ext_gnt,
  output logic              ext_rvalid,
  output logic [DATA_W-1:0] ext_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_wen,
  output logic              mem_ren,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam logic [AGE_W-1:0] LIMIT = AGE_W'(STARVE_LIMIT);

  logic             w_c;
  logic             w_e;
  logic [AGE_W-1:0] w_age;
  logic [1:0]       w_owner;
  logic             w_grant_cpu;
  logic             w_grant_ext;

  arb_state_t       r_state;
  arb_state_t       w_state_next;
  logic [DATA_W-1:0] r_cpu_rdata;
  logic [DATA_W-1:0] r_ext_rdata;

  assign w_c = cpu_req & enable;
  assign w_e = ext_req;

  // Starved ext overrides CPU priority; otherwise ext only takes idle cycles.
  always_comb begin
    w_owner = OWN_NONE;
    if (w_e && (w_age >= LIMIT)) begin
      w_owner = OWN_EXT;
    end else if (w_c) begin
      w_owner = OWN_CPU;
    end else if (w_e) begin
      w_owner = OWN_EXT;
    end
  end

  assign w_grant_cpu = (w_owner == OWN_CPU);
  assign w_grant_ext = (w_owner == OWN_EXT);
  assign cpu_stall   = w_c & ~w_grant_cpu;
  assign ext_gnt     = w_grant_ext;

  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    mem_wen   = 1'b0;
    mem_ren   = 1'b0;
    unique case (w_owner)
      OWN_CPU: begin
        mem_addr  = cpu_addr;
        mem_wdata = cpu_wdata;
        mem_wen   = cpu_we;
        mem_ren   = ~cpu_we;
      end
      OWN_EXT: begin
        mem_addr  = ext_addr;
        mem_wdata = ext_wdata;
        mem_wen   = ext_we;
        mem_ren   = ~ext_we;
      end
      default: ;
    endcase
  end

  dmem_arbiter_age_counter u_age (
    .clk     (clk),
    .arst_n  (arst_n),
    .i_inc   (w_e & ~w_grant_ext),
    .i_clr   (w_grant_ext | ~w_e),
    .o_count (w_age)
  );

  // Read-return FSM: state register.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_state <= ARB_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next state depends only on this cycle's grant, so reads pipeline one per cycle.
  always_comb begin
    w_state_next = ARB_IDLE;
    if (w_grant_cpu && !cpu_we) begin
      w_state_next = ARB_CPU_RD;
    end else if (w_grant_ext && !ext_we) begin
      w_state_next = ARB_EXT_RD;
    end
  end

  // Return data is forwarded on the return cycle and held afterwards.
  always_comb begin
    cpu_rvalid = (r_state == ARB_CPU_RD);
    ext_rvalid = (r_state == ARB_EXT_RD);
    cpu_rdata  = cpu_rvalid ? mem_rdata : r_cpu_rdata;
    ext_rdata  = ext_rvalid ? mem_rdata : r_ext_rdata;
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_cpu_rdata <= '0;
      r_ext_rdata <= '0;
    end else begin
      if (r_state == ARB_CPU_RD) begin
        r_cpu_rdata <= mem_rdata;
      end
      if (r_state == ARB_EXT_RD) begin
        r_ext_rdata <= mem_rdata;
      end
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Randomized + directed bench for dmem_arbiter against a cycle-level behavioural model.
module tb_dmem_arbiter;

  localparam int unsigned LIMIT = 4;

  logic        clk;
  logic        arst_n;
  logic        enable;
  logic        cpu_req;
  logic        cpu_we;
  logic [63:0] cpu_addr;
  logic [63:0] cpu_wdata;
  logic        cpu_stall;
  logic        cpu_rvalid;
  logic [63:0] cpu_rdata;
  logic        ext_req;
  logic        ext_we;
  logic [63:0] ext_addr;
  logic [63:0] ext_wdata;
  logic        ext_gnt;
  logic        ext_rvalid;
  logic [63:0] ext_rdata;
  logic [63:0] mem_addr;
  logic        mem_wen;
  logic        mem_ren;
  logic [63:0] mem_wdata;
  logic [63:0] mem_rdata;

  dmem_arbiter #(
    .DATA_W       (64),
    .ADDR_W       (64),
    .STARVE_LIMIT (LIMIT)
  ) dut (
    .clk        (clk),
    .arst_n     (arst_n),
    .enable     (enable),
    .cpu_req    (cpu_req),
    .cpu_we     (cpu_we),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_stall  (cpu_stall),
    .cpu_rvalid (cpu_rvalid),
    .cpu_rdata  (cpu_rdata),
    .ext_req    (ext_req),
    .ext_we     (ext_we),
    .ext_addr   (ext_addr),
    .ext_wdata  (ext_wdata),
    .ext_gnt    (ext_gnt),
    .ext_rvalid (ext_rvalid),
    .ext_rdata  (ext_rdata),
    .mem_addr   (mem_addr),
    .mem_wen    (mem_wen),
    .mem_ren    (mem_ren),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // SRAM environment: 32 x 64-bit words, address truncated to bits [7:3].
  logic [63:0] sram [0:31];
  always @(posedge clk) begin
    if (mem_wen) sram[mem_addr[7:3]] <= mem_wdata;
    if (mem_ren) mem_rdata <= sram[mem_addr[7:3]];
  end

  int n_checks;
  int n_pass;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
  endtask

  // Reference model state
  logic [63:0] ref_mem [0:31];
  int unsigned m_age;
  int          m_pend;      // 0 none, 1 cpu read returning, 2 ext read returning
  logic [63:0] m_pend_data;
  logic [63:0] m_cpu_rdata;
  logic [63:0] m_ext_rdata;

  task automatic model_reset();
    m_age       = 0;
    m_pend      = 0;
    m_pend_data = '0;
    m_cpu_rdata = '0;
    m_ext_rdata = '0;
  endtask

  // One clock cycle: drive, check against the model at negedge, advance the model.
  task automatic cyc(input logic cr, input logic cwe, input logic [63:0] ca,
                     input logic [63:0] cwd, input logic en, input logic er,
                     input logic ewe, input logic [63:0] ea, input logic [63:0] ewd,
                     output int g);
    logic        c;
    logic        exp_we;
    logic [63:0] exp_addr;
    logic [63:0] exp_wd;
    logic [63:0] exp_crd;
    logic [63:0] exp_erd;
    @(posedge clk);
    #1;
    cpu_req = cr; cpu_we = cwe; cpu_addr = ca; cpu_wdata = cwd; enable = en;
    ext_req = er; ext_we = ewe; ext_addr = ea; ext_wdata = ewd;
    c = cr & en;
    if (er && m_age >= LIMIT) g = 2;
    else if (c) g = 1;
    else if (er) g = 2;
    else g = 0;
    exp_we   = (g == 1) ? cwe : (g == 2) ? ewe : 1'b0;
    exp_addr = (g == 1) ? ca : (g == 2) ? ea : 64'h0;
    exp_wd   = (g == 1) ? cwd : (g == 2) ? ewd : 64'h0;
    exp_crd  = (m_pend == 1) ? m_pend_data : m_cpu_rdata;
    exp_erd  = (m_pend == 2) ? m_pend_data : m_ext_rdata;
    @(negedge clk);
    check("cpu_stall", cpu_stall, c && g != 1);
    check("ext_gnt", ext_gnt, g == 2);
    check("mem_wen", mem_wen, g != 0 && exp_we);
    check("mem_ren", mem_ren, g != 0 && !exp_we);
    check("mem_addr", mem_addr, exp_addr);
    check("mem_wdata", mem_wdata, exp_wd);
    check("cpu_rvalid", cpu_rvalid, m_pend == 1);
    check("ext_rvalid", ext_rvalid, m_pend == 2);
    check("cpu_rdata", cpu_rdata, exp_crd);
    check("ext_rdata", ext_rdata, exp_erd);
    m_cpu_rdata = exp_crd;
    m_ext_rdata = exp_erd;
    m_pend = 0;
    if (g != 0) begin
      if (exp_we) begin
        ref_mem[exp_addr[7:3]] = exp_wd;
      end else begin
        m_pend      = g;
        m_pend_data = ref_mem[exp_addr[7:3]];
      end
    end
    if (er && g != 2) m_age = (m_age < 15) ? m_age + 1 : 15;
    else m_age = 0;
  endtask

  task automatic idle(output int g);
    cyc(1'b0, 1'b0, 64'h0, 64'h0, 1'b1, 1'b0, 1'b0, 64'h0, 64'h0, g);
  endtask

  initial begin
    int          g;
    logic        e_req;
    logic        e_we;
    logic [63:0] e_addr;
    logic [63:0] e_wd;
    logic [63:0] ca;

    n_checks = 0;
    n_pass   = 0;
    for (int i = 0; i < 32; i++) begin
      sram[i]    = 64'h1111_0000 + 64'(i);
      ref_mem[i] = 64'h1111_0000 + 64'(i);
    end
    sram[4]    = 64'h1234;
    ref_mem[4] = 64'h1234;
    model_reset();

    arst_n = 1'b0;
    enable = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    ext_req = 1'b0; ext_we = 1'b0; ext_addr = '0; ext_wdata = '0;
    #3;
    check("rst_cpu_rvalid", cpu_rvalid, 1'b0);
    check("rst_ext_rvalid", ext_rvalid, 1'b0);
    check("rst_cpu_rdata", cpu_rdata, 64'h0);
    check("rst_ext_rdata", ext_rdata, 64'h0);
    check("rst_stall", cpu_stall, 1'b0);
    check("rst_gnt", ext_gnt, 1'b0);
    check("rst_mem_en", {mem_wen, mem_ren}, 2'b00);
    #9;
    arst_n = 1'b1;

    // CPU write then read back
    cyc(1'b1, 1'b1, 64'h10, 64'hDEADBEEF, 1'b1, 1'b0, 1'b0, 64'h0, 64'h0, g);
    check("t1_wen", mem_wen, 1'b1);
    cyc(1'b1, 1'b0, 64'h10, 64'h0, 1'b1, 1'b0, 1'b0, 64'h0, 64'h0, g);
    check("t1_ren", mem_ren, 1'b1);
    idle(g);
    check("t1_rvalid", cpu_rvalid, 1'b1);
    check("t1_rdata", cpu_rdata, 64'hDEADBEEF);

    // Ext-only read
    cyc(1'b0, 1'b0, 64'h0, 64'h0, 1'b1, 1'b1, 1'b0, 64'h20, 64'h0, g);
    check("t2_gnt", ext_gnt, 1'b1);
    idle(g);
    check("t2_rvalid", ext_rvalid, 1'b1);
    check("t2_rdata", ext_rdata, 64'h1234);

    // Contention for 8 cycles: ext wins once, in cycle 4
    idle(g);
    for (int i = 0; i < 8; i++) begin
      cyc(1'b1, 1'b0, 64'h0, 64'h0, 1'b1, 1'b1, 1'b1, 64'h18, 64'hAA, g);
      check("t3_gnt", ext_gnt, i == 4);
      check("t3_stall", cpu_stall, i == 4);
    end
    idle(g);

    // Back-to-back reads to alternating owners
    cyc(1'b1, 1'b0, 64'h00, 64'h0, 1'b1, 1'b0, 1'b0, 64'h0, 64'h0, g);
    cyc(1'b0, 1'b0, 64'h0, 64'h0, 1'b1, 1'b1, 1'b0, 64'h08, 64'h0, g);
    check("t4_cpu_rvalid", cpu_rvalid, 1'b1);
    cyc(1'b1, 1'b0, 64'h10, 64'h0, 1'b1, 1'b0, 1'b0, 64'h0, 64'h0, g);
    check("t4_ext_rdata", ext_rdata, 64'h1111_0001);
    idle(g);
    check("t4_cpu_rdata", cpu_rdata, 64'hDEADBEEF);

    // enable=0 masks the CPU request
    cyc(1'b1, 1'b0, 64'h10, 64'h0, 1'b0, 1'b0, 1'b0, 64'h0, 64'h0, g);
    check("t5_stall", cpu_stall, 1'b0);
    check("t5_ren", {mem_wen, mem_ren}, 2'b00);

    // Reset during the return cycle of a CPU read drops it
    cyc(1'b1, 1'b0, 64'h08, 64'h0, 1'b1, 1'b0, 1'b0, 64'h0, 64'h0, g);
    @(posedge clk);
    #1;
    cpu_req = 1'b0; ext_req = 1'b0;
    arst_n = 1'b0;
    #1;
    check("t6_rvalid", cpu_rvalid, 1'b0);
    check("t6_cpu_rdata", cpu_rdata, 64'h0);
    check("t6_ext_rdata", ext_rdata, 64'h0);
    model_reset();
    @(negedge clk);
    arst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      cyc(1'b1, 1'b0, 64'h10, 64'h0, 1'b1, 1'b1, 1'b0, 64'h20, 64'h0, g);
      check("t6_resume_gnt", ext_gnt, i == 4);
    end
    idle(g);

    // Randomized traffic; ext holds its request until granted
    e_req = 1'b0; e_we = 1'b0; e_addr = '0; e_wd = '0;
    for (int i = 0; i < 400; i++) begin
      if (!e_req && $urandom_range(0, 1) == 1) begin
        e_req  = 1'b1;
        e_we   = $urandom_range(0, 2) == 0;
        e_addr = 64'($urandom_range(0, 31)) << 3;
        e_wd   = {$urandom(), $urandom()};
      end
      ca = 64'($urandom_range(0, 31)) << 3;
      if ($urandom_range(0, 3) == 0) ca[63:32] = $urandom();
      cyc($urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0, ca,
          {$urandom(), $urandom()}, $urandom_range(0, 7) != 0,
          e_req, e_we, e_addr, e_wd, g);
      if (g == 2) e_req = 1'b0;
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
